// File: rtl/imem_program_loader.sv
// Serial byte-stream loader for the instruction memory: packs bytes
// big-endian into 32-bit words and writes them through the load port.
module imem_program_loader #(
   parameter int MEM_BYTES = 512,
   parameter int ADDR_W    = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [ADDR_W:0]   byte_count,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(MEM_BYTES);
   localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

   state_t              state_q, state_d;
   logic                byte_ready_q, byte_ready_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [31:0]         wr_data_q, wr_data_d;
   logic [ADDR_W:0]     byte_count_q, byte_count_d;
   logic                cpu_hold_q, cpu_hold_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic [23:0]         shift_q, shift_d;
   logic [1:0]          idx_q, idx_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;

   logic                accept;
   logic                load_start;
   logic [ADDR_W:0]     cnt_inc;
   logic [31:0]         padded;

   assign accept     = byte_valid & byte_ready_q;
   assign load_start = start & ((state_q == S_IDLE) |
                                (state_q == S_DONE) |
                                (state_q == S_ERROR));
   assign cnt_inc    = (byte_count_q == FULL_CNT) ? byte_count_q
                                                  : byte_count_q + CNT_ONE;

   // Final partial word: left-aligned, low bytes zero.
   always_comb begin
      padded = 32'h0;
      unique case (idx_q)
         2'd0:    padded = {byte_data, 24'h0};
         2'd1:    padded = {shift_q[7:0], byte_data, 16'h0};
         default: padded = {shift_q[15:0], byte_data, 8'h0};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (accept) begin
               if (byte_last)
                  state_d = (idx_q == 2'd3) ? S_DONE : S_FLUSH;
               else if (cnt_inc == FULL_CNT)
                  state_d = S_ERROR;
            end
         end
         S_FLUSH: state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      byte_ready_d = (state_d == S_LOAD);
      done_d       = (state_d == S_DONE);
      error_d      = (state_d == S_ERROR);
      cpu_hold_d   = (state_d == S_LOAD) | (state_d == S_FLUSH) |
                     (state_d == S_ERROR);
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      byte_count_d = byte_count_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      waddr_d      = waddr_q;
      if (load_start) begin
         byte_count_d = '0;
         shift_d      = '0;
         idx_d        = '0;
         waddr_d      = '0;
      end else if (accept) begin
         shift_d      = {shift_q[15:0], byte_data};
         idx_d        = idx_q + 2'd1;
         byte_count_d = cnt_inc;
         if (idx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = waddr_q;
            wr_data_d = {shift_q, byte_data};
            waddr_d   = waddr_q + WORD_STEP;
         end else if (byte_last) begin
            wr_en_d   = 1'b1;
            wr_addr_d = waddr_q;
            wr_data_d = padded;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_ready_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         byte_count_q <= '0;
         cpu_hold_q   <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         shift_q      <= '0;
         idx_q        <= '0;
         waddr_q      <= '0;
      end else begin
         byte_ready_q <= byte_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         byte_count_q <= byte_count_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         error_q      <= error_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         waddr_q      <= waddr_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign byte_count = byte_count_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader with a 16-byte memory
// so the overflow path is reachable in a few cycles.
module tb_imem_program_loader;

   localparam int MEM_BYTES = 16;
   localparam int ADDR_W    = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_last;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [ADDR_W:0]   byte_count;
   logic              cpu_hold;
   logic              done;
   logic              error;

   int n_vec = 0;
   int n_err = 0;

   logic [ADDR_W-1:0] mon_addr [0:63];
   logic [31:0]       mon_data [0:63];
   int                n_wr = 0;

   imem_program_loader #(
      .MEM_BYTES (MEM_BYTES),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_last  (byte_last),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .byte_count (byte_count),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en === 1'b1 && n_wr < 64) begin
         mon_addr[n_wr] = wr_addr;
         mon_data[n_wr] = wr_data;
         n_wr++;
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [7:0] d, input logic l);
      byte_valid = 1'b1;
      byte_data  = d;
      byte_last  = l;
      tick();
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".ready"}, 32'(byte_ready), 32'd0);
      check({tag, ".wr_en"}, 32'(wr_en), 32'd0);
      check({tag, ".addr"}, 32'(wr_addr), 32'd0);
      check({tag, ".data"}, wr_data, 32'd0);
      check({tag, ".count"}, 32'(byte_count), 32'd0);
      check({tag, ".hold"}, 32'(cpu_hold), 32'd0);
      check({tag, ".done"}, 32'(done), 32'd0);
      check({tag, ".error"}, 32'(error), 32'd0);
   endtask

   initial begin
      int base;
      logic [7:0] prog [0:7];
      logic       vpat [0:6];
      logic [7:0] gbytes [0:3];
      int         gi;

      prog[0] = 8'h00; prog[1] = 8'h10; prog[2] = 8'h00; prog[3] = 8'h93;
      prog[4] = 8'h00; prog[5] = 8'h20; prog[6] = 8'h01; prog[7] = 8'h13;
      vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1;
      vpat[4] = 1; vpat[5] = 0; vpat[6] = 1;
      gbytes[0] = 8'h11; gbytes[1] = 8'h22;
      gbytes[2] = 8'h33; gbytes[3] = 8'h44;

      // reset with byte_valid high
      rst = 1'b1; start = 1'b0;
      byte_valid = 1'b1; byte_data = 8'hAA; byte_last = 1'b0;
      tick();
      tick();
      check_idle("rst");
      check("rst.nwr", 32'(n_wr), 32'd0);
      rst = 1'b0;
      tick();
      check("idle.ready", 32'(byte_ready), 32'd0);
      check("idle.count", 32'(byte_count), 32'd0);
      byte_valid = 1'b0;

      // two full words
      base = n_wr;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("fw.ready", 32'(byte_ready), 32'd1);
      check("fw.hold", 32'(cpu_hold), 32'd1);
      for (int i = 0; i < 8; i++) begin
         put(prog[i], i == 7);
         if (i == 3) begin
            check("fw.w0.en", 32'(wr_en), 32'd1);
            check("fw.w0.addr", 32'(wr_addr), 32'd0);
            check("fw.w0.data", wr_data, 32'h00100093);
         end
      end
      check("fw.w1.en", 32'(wr_en), 32'd1);
      check("fw.w1.addr", 32'(wr_addr), 32'd4);
      check("fw.w1.data", wr_data, 32'h00200113);
      check("fw.done", 32'(done), 32'd1);
      tick();
      check("fw.nwr", 32'(n_wr - base), 32'd2);
      check("fw.count", 32'(byte_count), 32'd8);
      check("fw.hold0", 32'(cpu_hold), 32'd0);
      check("fw.ready0", 32'(byte_ready), 32'd0);
      check("fw.en0", 32'(wr_en), 32'd0);

      // reload from DONE, partial word
      base = n_wr;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("pw.done0", 32'(done), 32'd0);
      check("pw.count0", 32'(byte_count), 32'd0);
      check("pw.hold", 32'(cpu_hold), 32'd1);
      put(8'hDE, 1'b0);
      put(8'hAD, 1'b0);
      put(8'hBE, 1'b1);
      check("pw.flush.en", 32'(wr_en), 32'd1);
      check("pw.flush.addr", 32'(wr_addr), 32'd0);
      check("pw.flush.data", wr_data, 32'hDEADBE00);
      check("pw.flush.done", 32'(done), 32'd0);
      check("pw.flush.ready", 32'(byte_ready), 32'd0);
      tick();
      check("pw.done", 32'(done), 32'd1);
      check("pw.en0", 32'(wr_en), 32'd0);
      check("pw.count", 32'(byte_count), 32'd3);
      check("pw.nwr", 32'(n_wr - base), 32'd1);

      // gaps in byte_valid
      base = n_wr;
      start = 1'b1;
      tick();
      start = 1'b0;
      gi = 0;
      for (int i = 0; i < 7; i++) begin
         byte_valid = vpat[i];
         byte_data  = vpat[i] ? gbytes[gi] : 8'hFF;
         byte_last  = vpat[i] && (gi == 3);
         if (vpat[i]) gi++;
         tick();
         if (i == 2)
            check("gap.count", 32'(byte_count), 32'd1);
      end
      byte_valid = 1'b0; byte_last = 1'b0;
      check("gap.en", 32'(wr_en), 32'd1);
      check("gap.data", wr_data, 32'h11223344);
      check("gap.addr", 32'(wr_addr), 32'd0);
      check("gap.count4", 32'(byte_count), 32'd4);
      tick();
      check("gap.nwr", 32'(n_wr - base), 32'd1);
      check("gap.done", 32'(done), 32'd1);

      // overflow
      base = n_wr;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 16; i++) put(8'(i), 1'b0);
      check("ov.en", 32'(wr_en), 32'd1);
      check("ov.addr", 32'(wr_addr), 32'd12);
      check("ov.data", wr_data, 32'h0C0D0E0F);
      check("ov.error", 32'(error), 32'd1);
      check("ov.hold", 32'(cpu_hold), 32'd1);
      check("ov.ready", 32'(byte_ready), 32'd0);
      check("ov.count", 32'(byte_count), 32'd16);
      put(8'h77, 1'b0);
      put(8'h78, 1'b1);
      check("ov.nwr", 32'(n_wr - base), 32'd4);
      check("ov.a0", 32'(mon_addr[base]), 32'd0);
      check("ov.d0", mon_data[base], 32'h00010203);
      check("ov.a1", 32'(mon_addr[base+1]), 32'd4);
      check("ov.d1", mon_data[base+1], 32'h04050607);
      check("ov.a2", 32'(mon_addr[base+2]), 32'd8);
      check("ov.d2", mon_data[base+2], 32'h08090A0B);
      check("ov.count.hold", 32'(byte_count), 32'd16);
      check("ov.done", 32'(done), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ov.restart.count", 32'(byte_count), 32'd0);
      check("ov.restart.error", 32'(error), 32'd0);
      check("ov.restart.ready", 32'(byte_ready), 32'd1);

      // mid-load reset on the 6th byte
      base = n_wr;
      for (int i = 0; i < 5; i++) put(8'hA0 + 8'(i), 1'b0);
      rst = 1'b1;
      put(8'hA5, 1'b0);
      check_idle("mrst");
      start = 1'b1;
      tick();
      check("mrst.start.ready", 32'(byte_ready), 32'd0);
      rst = 1'b0;
      start = 1'b0;
      tick();
      tick();
      check("mrst.nwr", 32'(n_wr - base), 32'd1);
      check("mrst.a0", 32'(mon_addr[base]), 32'd0);
      check("mrst.d0", mon_data[base], 32'hA0A1A2A3);

      // start with byte_valid in IDLE: byte not taken
      base = n_wr;
      start = 1'b1; byte_valid = 1'b1; byte_data = 8'h99;
      tick();
      start = 1'b0; byte_valid = 1'b0;
      check("sv.count", 32'(byte_count), 32'd0);
      check("sv.ready", 32'(byte_ready), 32'd1);
      put(8'h55, 1'b1);
      check("sv.data", wr_data, 32'h55000000);
      tick();
      check("sv.done", 32'(done), 32'd1);
      check("sv.nwr", 32'(n_wr - base), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer-side companion to the byte-addressed instruction memory.
- Receives a program as a serial byte stream over a valid/ready handshake and packs each 4 bytes into one big-endian 32-bit word, so the first byte received lands at the lowest address and becomes instruction[31:24] on fetch.
- Issues registered word writes into the instruction memory's load port.
- Holds the CPU pipeline while loading and reports completion or overflow.

Parameters:
- MEM_BYTES, 512, instruction memory size in bytes; must be a multiple of 4.
- ADDR_W, 9, byte-address width; must satisfy 2**ADDR_W == MEM_BYTES.

Ports:
- clk  in  1  system clock; rising edge only.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load at address 0.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  program byte.
- byte_last  in  1  qualifies the accepted byte as the final program byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  one-cycle word write strobe to instruction memory.
- wr_addr  out  ADDR_W  byte address of the written word; always a multiple of 4.
- wr_data  out  32  word data; wr_data[31:24] goes to wr_addr, [7:0] goes to wr_addr+3.
- byte_count  out  ADDR_W+1  bytes accepted since the last start.
- cpu_hold  out  1  keeps the processor stalled/reset while high.
- done  out  1  load completed; level signal.
- error  out  1  overflow; level signal.

Behaviour:
- Reset (synchronous, active-high): state IDLE.
  - All outputs 0: byte_ready, wr_en, wr_addr, wr_data, byte_count, cpu_hold, done, error.
  - Internal shift register and byte index (0..3) cleared.
  - rst asserted in any state, including mid-word or mid-write, aborts the load with no further write.
- States: IDLE, LOAD, FLUSH, DONE, ERROR.
- IDLE:
  - byte_ready = 0; byte_valid is ignored.
  - start -> LOAD next cycle.
- Load entry, from IDLE, DONE or ERROR on start:
  - Clears byte_count, the index, the word address and the shift register.
  - Sets cpu_hold = 1; clears done and error.
- LOAD:
  - byte_ready = 1 (registered, high the whole state).
  - Accept = byte_valid && byte_ready. Each accept shifts: word = {word[23:0], byte_data}; index++; byte_count++.
  - On an accept with index == 3, the assembled word is registered into wr_data.
    - wr_addr = current word address; wr_en = 1 on the next cycle only.
    - Word address += 4; index wraps to 0.
  - Acceptance continues back-to-back during the write cycle; throughput is 1 byte/cycle.
  - byte_last on an accept:
    - Completes a word (index == 3): write as above; state -> DONE; byte_ready drops the cycle after the accept.
    - Index 0..2: state -> FLUSH; byte_ready = 0.
  - Overflow: an accept without byte_last that brings byte_count to MEM_BYTES still writes its word, then state -> ERROR.
  - start while in LOAD is ignored.
- FLUSH (exactly one cycle):
  - Left-aligns the partial word and pads the low bytes with 0x00. Example: 2 bytes AB,CD -> 0xABCD0000.
  - wr_en = 1 with wr_addr = current word address.
  - Next state is DONE.
- DONE:
  - done = 1; cpu_hold = 0.
  - byte_count frozen; wr_en = 0.
  - start -> new load (reload).
- ERROR:
  - error = 1; cpu_hold stays 1.
  - No writes; byte_ready = 0.
  - Only start or rst exits.
- Simultaneous events:
  - rst beats start.
  - start in IDLE with byte_valid high in the same cycle: that byte is not accepted, because byte_ready is still 0.
- Latency: accept of a word-completing byte at cycle N -> wr_en at N+1. Last partial byte at N -> FLUSH write at N+1 -> done at N+2.
- Width rules:
  - byte_count saturates at MEM_BYTES (ADDR_W+1 bits).
  - wr_addr never exceeds MEM_BYTES-4.

Test Plan:
- Reset: rst for 2 cycles with byte_valid=1 -> all outputs 0; no wr_en.
- Full words: start, then bytes 00,10,00,93,00,20,01,13 (last on 8th) -> wr_en@addr0 data 0x00100093, wr_en@addr4 data 0x00200113; byte_count=8; done=1; cpu_hold=0.
- Partial word: start, then bytes DE,AD,BE (last on BE) -> FLUSH writes 0xDEADBE00 at addr 0; done one cycle later; byte_count=3.
- Backpressure/gaps: byte_valid toggled 1,0,0,1,1,0,1 with 4 bytes 11,22,33,44 (last) -> single write 0x11223344 at addr 0; only valid cycles counted.
- Overflow (MEM_BYTES=16): 16 bytes with no last -> 4 writes (addr 0,4,8,12); then error=1, cpu_hold=1, byte_ready=0; start -> LOAD with byte_count=0.
- Mid-load reset and reload: 6 bytes sent, rst at the 6th -> IDLE, no pending write at addr 4. A DONE state followed by start reloads from addr 0 and drops done.
